// File: rtl/lcd_rgb_rx_monitor.sv
// Receive-side monitor for a parallel RGB565 LCD bus: registers the pins, recovers pixel
// coordinates, measures frame geometry and tracks a SEARCH/ACQUIRE/LOCKED status.
module lcd_rgb_rx_monitor #(
  parameter int CW          = 12,
  parameter int EXP_WIDTH   = 800,
  parameter int EXP_HEIGHT  = 480,
  parameter bit HS_ACT      = 1'b0,
  parameter bit VS_ACT      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          LCD_DE,
  input  logic          LCD_HSYNC,
  input  logic          LCD_VSYNC,
  input  logic [4:0]    LCD_R,
  input  logic [5:0]    LCD_G,
  input  logic [4:0]    LCD_B,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [15:0]   pix_rgb,
  output logic          frame_done,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_height,
  output logic [CW-1:0] meas_htotal,
  output logic [15:0]   frame_sum,
  output logic          err_geom,
  output logic [7:0]    err_count,
  output logic          locked
);
  typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  state_t        state;
  logic          de_s1, hs_s1, vs_s1, de_d, hs_d, vs_d;
  logic [15:0]   rgb_s1;
  logic [CW-1:0] run_len, y_cnt, line_width, h_cnt, h_latch;
  logic          have_width, line_bad;
  logic [15:0]   sum_acc;
  logic [7:0]    good_cnt;

  logic          vs_edge, hs_edge, run_start, run_end, take_pix, frame_good, close_bad;
  logic [CW-1:0] close_width, close_height;

  // Sync levels are normalised to "active" in stage 1 so edge logic is polarity-free.
  // NOTE: every register is written with <= so all flops update from the same pre-edge values.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de_s1  <= 1'b0;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      rgb_s1 <= '0;
      de_d   <= 1'b0;
      hs_d   <= 1'b0;
      vs_d   <= 1'b0;
    end else begin
      de_s1  <= LCD_DE;
      hs_s1  <= (LCD_HSYNC == HS_ACT);
      vs_s1  <= (LCD_VSYNC == VS_ACT);
      rgb_s1 <= {LCD_R, LCD_G, LCD_B};
      de_d   <= de_s1;
      hs_d   <= hs_s1;
      vs_d   <= vs_s1;
    end
  end

  // A VS edge both ends the running DE run and starts a fresh one if DE stays high.
  // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
  always_comb begin
    vs_edge      = vs_s1 && !vs_d;
    hs_edge      = hs_s1 && !hs_d && (state != ST_SEARCH);
    run_start    = de_s1 && (!de_d || vs_edge);
    run_end      = de_d && (!de_s1 || vs_edge);
    take_pix     = de_s1 && ((state != ST_SEARCH) || vs_edge);
    close_width  = (!have_width && run_end) ? run_len : line_width;
    close_bad    = line_bad || (have_width && run_end && (run_len != line_width));
    close_height = run_end ? sat_inc(y_cnt) : y_cnt;
    frame_good   = (close_width == CW'(EXP_WIDTH)) && (close_height == CW'(EXP_HEIGHT)) && !close_bad;
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_SEARCH;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      meas_htotal <= '0;
      frame_sum   <= '0;
      err_geom    <= 1'b0;
      err_count   <= '0;
      locked      <= 1'b0;
      run_len     <= '0;
      y_cnt       <= '0;
      line_width  <= '0;
      have_width  <= 1'b0;
      line_bad    <= 1'b0;
      h_cnt       <= '0;
      h_latch     <= '0;
      sum_acc     <= '0;
      good_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      pix_valid  <= take_pix;
      if (take_pix) begin
        pix_x   <= run_start ? '0 : run_len;
        pix_y   <= vs_edge ? '0 : y_cnt;
        pix_rgb <= rgb_s1;
      end

      if (state != ST_SEARCH) begin
        if (hs_edge) begin
          h_latch <= h_cnt;
          h_cnt   <= CW'(1);
        end else begin
          h_cnt <= sat_inc(h_cnt);
        end
      end

      if (vs_edge) begin
        y_cnt      <= '0;
        run_len    <= de_s1 ? CW'(1) : '0;
        sum_acc    <= de_s1 ? rgb_s1 : '0;
        have_width <= 1'b0;
        line_width <= '0;
        line_bad   <= 1'b0;
        if (state == ST_SEARCH) begin
          state    <= ST_ACQUIRE;
          good_cnt <= '0;
        end else begin
          frame_done  <= 1'b1;
          meas_width  <= close_width;
          meas_height <= close_height;
          meas_htotal <= hs_edge ? h_cnt : h_latch;
          frame_sum   <= sum_acc;
          err_geom    <= !frame_good;
          case (state)
            ST_ACQUIRE: begin
              if (!frame_good) begin
                good_cnt <= '0;
              end else if (good_cnt + 8'd1 >= 8'(LOCK_FRAMES)) begin
                state    <= ST_LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 8'd1;
              end
            end
            ST_LOCKED: begin
              if (!frame_good) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                state    <= ST_ACQUIRE;
                locked   <= 1'b0;
                good_cnt <= '0;
              end
            end
            default: ;
          endcase
        end
      end else if (state != ST_SEARCH) begin
        if (run_end) begin
          y_cnt <= sat_inc(y_cnt);
          if (!have_width) begin
            line_width <= run_len;
            have_width <= 1'b1;
          end else if (run_len != line_width) begin
            line_bad <= 1'b1;
          end
        end
        if (de_s1) begin
          run_len <= run_start ? CW'(1) : sat_inc(run_len);
          sum_acc <= sum_acc + rgb_s1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_rgb_rx_monitor.sv
// Bench for lcd_rgb_rx_monitor: frame-level reference model with pixel and frame scoreboards,
// directed geometry scenarios, randomized frames and an err_count saturation run.
module tb_lcd_rgb_rx_monitor;
  localparam int CW = 12;
  localparam int EW = 8;
  localparam int EH = 4;
  localparam int LF = 2;
  localparam int HT = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          de = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [4:0]    r = '0, b = '0;
  logic [5:0]    g = '0;
  logic          pix_valid, frame_done, err_geom, locked;
  logic [CW-1:0] pix_x, pix_y, meas_width, meas_height, meas_htotal;
  logic [15:0]   pix_rgb, frame_sum;
  logic [7:0]    err_count;

  lcd_rgb_rx_monitor #(
    .CW(CW), .EXP_WIDTH(EW), .EXP_HEIGHT(EH), .HS_ACT(1'b0), .VS_ACT(1'b0), .LOCK_FRAMES(LF)
  ) dut (
    .PixelClk(clk), .nRST(rst_n), .LCD_DE(de), .LCD_HSYNC(hs), .LCD_VSYNC(vs),
    .LCD_R(r), .LCD_G(g), .LCD_B(b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .meas_width(meas_width), .meas_height(meas_height),
    .meas_htotal(meas_htotal), .frame_sum(frame_sum), .err_geom(err_geom),
    .err_count(err_count), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int x; int y; int rgb; int at; } pix_t;
  typedef struct { int width; int height; int htotal; int sum; int err; int errc; int lck; int at; } frm_t;

  pix_t exp_pix[$];
  frm_t exp_frm[$];
  int   plan[$];

  // Reference model state: 0 = searching, 1 = acquiring, 2 = locked.
  int          m_state = 0, m_good = 0, m_errc = 0;
  int          f_lines[$];
  logic [15:0] f_sum = '0;

  int errors = 0, checks = 0, pv_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_pix.delete();
    exp_frm.delete();
    f_lines.delete();
    m_state = 0;
    m_good  = 0;
    m_errc  = 0;
    f_sum   = '0;
  endtask

  // Frame close as seen from whole-frame statistics.
  task automatic model_vs(input int at);
    frm_t f;
    int   w, h;
    bit   bad, good;
    if (m_state == 0) begin
      m_state = 1;
      m_good  = 0;
    end else begin
      h   = f_lines.size();
      w   = (h > 0) ? f_lines[0] : 0;
      bad = 1'b0;
      foreach (f_lines[i]) if (f_lines[i] != w) bad = 1'b1;
      good = (w == EW) && (h == EH) && !bad;
      if (m_state == 1) begin
        m_good = good ? m_good + 1 : 0;
        if (m_good >= LF) begin
          m_state = 2;
          m_good  = 0;
        end
      end else if (!good) begin
        if (m_errc < 255) m_errc++;
        m_state = 1;
        m_good  = 0;
      end
      f.width = w; f.height = h; f.htotal = HT; f.sum = int'(f_sum);
      f.err = good ? 0 : 1; f.errc = m_errc; f.lck = (m_state == 2) ? 1 : 0; f.at = at + 2;
      exp_frm.push_back(f);
    end
    f_lines.delete();
    f_sum = '0;
  endtask

  task automatic drive(input bit d, input bit h_on, input bit v_on, input logic [15:0] px);
    de = d;
    hs = ~h_on;
    vs = ~v_on;
    {r, g, b} = px;
    @(posedge clk);
    #1;
  endtask

  // One 12-clock line: HS active for 2 clocks, DE from clock 2 for len clocks,
  // optional VS assertion starting at clock 2 (coincident with the DE rise).
  task automatic line(input int len, input bit vs_at, input bit rnd);
    bit          d, v;
    int          y;
    logic [15:0] px;
    pix_t        p;
    for (int c = 0; c < HT; c++) begin
      d  = (c >= 2) && (c < 2 + len);
      v  = vs_at && (c >= 2) && (c < 6);
      px = 16'h0000;
      if (v && c == 2) model_vs(cyc);
      if (d) begin
        y  = f_lines.size();
        px = rnd ? 16'($urandom_range(0, 65535)) : 16'((c - 2) + 16 * y);
        if (m_state != 0) begin
          p.x = c - 2; p.y = y; p.rgb = int'(px); p.at = cyc + 2;
          exp_pix.push_back(p);
          f_sum = f_sum + px;
        end
      end
      drive(d, c < 2, v, px);
    end
    if (len > 0 && m_state != 0) f_lines.push_back(len);
  endtask

  task automatic frame(input bit vs_on_data, input bit rnd);
    if (!vs_on_data || plan.size() == 0) line(0, 1'b1, rnd);
    foreach (plan[i]) line(plan[i], vs_on_data && (i == 0), rnd);
    line(0, 1'b0, rnd);
  endtask

  task automatic set_plan(input int n, input int len);
    plan.delete();
    for (int i = 0; i < n; i++) plan.push_back(len);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_rgb"}, pix_rgb, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_meas_width"}, meas_width, 0);
    check({tag, "_meas_height"}, meas_height, 0);
    check({tag, "_meas_htotal"}, meas_htotal, 0);
    check({tag, "_frame_sum"}, frame_sum, 0);
    check({tag, "_err_geom"}, err_geom, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_locked"}, locked, 0);
  endtask

  // Scoreboard: every strobed pixel and every frame_done is matched against the model.
  always @(negedge clk) begin
    pix_t ep;
    frm_t ef;
    if (rst_n) begin
      while (exp_pix.size() > 0 && exp_pix[0].at < cyc) begin
        check("pix_missing_cycle", cyc, exp_pix[0].at);
        ep = exp_pix.pop_front();
      end
      while (exp_frm.size() > 0 && exp_frm[0].at < cyc) begin
        check("frame_done_missing_cycle", cyc, exp_frm[0].at);
        ef = exp_frm.pop_front();
      end
      if (pix_valid) begin
        pv_seen++;
        if (exp_pix.size() == 0) begin
          check("pix_unexpected", pix_valid, 0);
        end else begin
          ep = exp_pix.pop_front();
          check("pix_cycle", cyc, ep.at);
          check("pix_x", pix_x, ep.x);
          check("pix_y", pix_y, ep.y);
          check("pix_rgb", pix_rgb, ep.rgb);
        end
      end
      if (frame_done) begin
        if (exp_frm.size() == 0) begin
          check("frame_done_unexpected", frame_done, 0);
        end else begin
          ef = exp_frm.pop_front();
          check("fd_cycle", cyc, ef.at);
          check("fd_meas_width", meas_width, ef.width);
          check("fd_meas_height", meas_height, ef.height);
          check("fd_meas_htotal", meas_htotal, ef.htotal);
          check("fd_frame_sum", frame_sum, ef.sum);
          check("fd_err_geom", err_geom, ef.err);
          check("fd_err_count", err_count, ef.errc);
          check("fd_locked", locked, ef.lck);
        end
      end
    end
  end

  initial begin
    int pv_before, n;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    rst_n = 1'b1;

    // Reset in the middle of a line, then no strobes until a VS edge is seen.
    set_plan(EH, EW);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    line(0, 1'b1, 1'b1);
    line(EW, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 16'hBEEF);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    pv_before = pv_seen;
    repeat (3) line(EW, 1'b0, 1'b1);
    check("search_no_pix_valid", pv_seen - pv_before, 0);

    // Three nominal frames with pixel value x+16*y.
    set_plan(EH, EW);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    check("f1_meas_width", meas_width, 8);
    check("f1_meas_height", meas_height, 4);
    check("f1_meas_htotal", meas_htotal, 12);
    check("f1_err_geom", err_geom, 0);
    check("f1_frame_sum", frame_sum, 16'h0370);  // 28*4 + 16*6*8
    frame(1'b0, 1'b0);
    check("lock_after_two_good", locked, 1);

    // Short third line while locked, then relock.
    plan.delete();
    plan.push_back(8); plan.push_back(8); plan.push_back(7); plan.push_back(8);
    frame(1'b0, 1'b1);
    set_plan(EH, EW);
    frame(1'b0, 1'b1);
    check("short_line_err_geom", err_geom, 1);
    check("short_line_err_count", err_count, 1);
    check("short_line_unlocked", locked, 0);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    check("relock", locked, 1);

    // Five-line frame, followed by a frame whose first DE rise coincides with the VS edge.
    set_plan(5, EW);
    frame(1'b0, 1'b1);
    set_plan(EH, EW);
    frame(1'b1, 1'b1);
    check("tall_meas_height", meas_height, 5);
    check("tall_err_geom", err_geom, 1);
    check("tall_err_count", err_count, 2);

    // Randomized frames: mostly nominal, some odd line lengths, counts, empty frames.
    for (int f = 0; f < 24; f++) begin
      plan.delete();
      n = int'($urandom_range(3, 5));
      for (int i = 0; i < n; i++)
        plan.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : EW);
      if ($urandom_range(0, 7) == 0) plan.delete();
      frame(plan.size() > 0 && $urandom_range(0, 1) == 1, 1'b1);
    end

    // Repeated lock / bad-frame cycles drive err_count into saturation.
    for (int i = 0; i < 300; i++) begin
      set_plan(EH, EW);
      frame(1'b0, 1'b1);
      frame(1'b0, 1'b1);
      plan.delete();
      frame(1'b0, 1'b1);
    end
    line(0, 1'b1, 1'b0);
    line(0, 1'b0, 1'b0);
    check("err_count_saturated", err_count, 255);
    check("pix_queue_drained", exp_pix.size(), 0);
    check("frame_queue_drained", exp_frm.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
